// File: rtl/auto_test_pkg.sv
// Shared definitions for the auto-test sequencer and its readback checker.
//   state_e     : checker FSM states (idle, run, report)
//   SeedDefault : default XOR seed for the expected test pattern
//   exp_word    : expected readback word for an address
package auto_test_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } state_e;

  localparam logic [15:0] SeedDefault = 16'hA5C3;

  // Expected word: the address replicated across the data width, XORed with the seed.
  // The TRG pattern is the bitwise complement of the DAQ pattern. Widths are passed
  // in so the same function serves any AW/DW pairing; callers truncate to DW.
  function automatic logic [63:0] exp_word(input logic [63:0] addr,
                                           input logic [63:0] seed,
                                           input logic        trg,
                                           input int unsigned aw,
                                           input int unsigned dw);
    logic [63:0] w;
    w = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < dw) w[i] = addr[i % aw];
    end
    w = w ^ seed;
    if (trg) w = ~w;
    return w;
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Saturating mismatch accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the running count at the next edge
//   inc      : 1-bit term added this cycle
//   sum      : running count plus this cycle's term, saturated (combinational)
module sat_acc #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] sum
);

  logic [CW-1:0] acc;

  // Holding at all-ones keeps the count from wrapping back to a small value.
  assign sum = (acc == {CW{1'b1}}) ? acc : acc + CW'(inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/auto_test_rbk_checker.sv
// Readback checker on the responder side of the auto-test sequencer.
// Owns the readback address counter, generates the expected word per address,
// compares readback data and publishes per-pass mismatch counts over a valid/ack port.
//   CLK, RST             : clock, asynchronous active-high reset
//   CLR_ADDR, INCR       : address counter strobes (clear has priority)
//   DAQ_CHK, TRG_CHK     : compare RBK_DATA against the DAQ / TRG pattern this cycle
//   UPDATE               : end of pass, publish result
//   USE_TEST_DATA        : test mode active
//   RBK_DATA             : readback word for the current ADDR
//   RPT_ACK              : report consumer acknowledge
//   ADDR, EXP_DATA       : readback address and its expected DAQ word
//   RPT_VLD, RPT_*_ERRS  : report valid and per-pass mismatch counts
//   RPT_PASS_CNT         : passes completed since leaving idle
//   ERR_FLAG, RPT_OVFL   : sticky mismatch / report-overwrite flags
module auto_test_rbk_checker
  import auto_test_pkg::*;
#(
  parameter int unsigned   AW   = 4,
  parameter int unsigned   DW   = 16,
  parameter int unsigned   CW   = 8,
  parameter logic [DW-1:0] SEED = DW'(SeedDefault)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLR_ADDR,
  input  logic          INCR,
  input  logic          DAQ_CHK,
  input  logic          TRG_CHK,
  input  logic          UPDATE,
  input  logic          USE_TEST_DATA,
  input  logic [DW-1:0] RBK_DATA,
  input  logic          RPT_ACK,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] EXP_DATA,
  output logic          RPT_VLD,
  output logic [CW-1:0] RPT_DAQ_ERRS,
  output logic [CW-1:0] RPT_TRG_ERRS,
  output logic [CW-1:0] RPT_PASS_CNT,
  output logic          ERR_FLAG,
  output logic          RPT_OVFL
);

  state_e        state;
  logic [DW-1:0] exp_daq;
  logic [DW-1:0] exp_trg;
  logic          active;
  logic          mis_daq;
  logic          mis_trg;
  logic          acc_clr;
  logic [CW-1:0] sum_daq;
  logic [CW-1:0] sum_trg;

  assign exp_daq  = DW'(exp_word(64'(ADDR), 64'(SEED), 1'b0, AW, DW));
  assign exp_trg  = DW'(exp_word(64'(ADDR), 64'(SEED), 1'b1, AW, DW));
  assign EXP_DATA = exp_daq;

  // Compares use the pre-increment ADDR; strobes are ignored while idle.
  assign active  = (state != StIdle);
  assign mis_daq = active & DAQ_CHK & (RBK_DATA != exp_daq);
  assign mis_trg = active & TRG_CHK & (RBK_DATA != exp_trg);

  // Idle holds the accumulators cleared, so entering RUN always starts from zero.
  assign acc_clr = (state == StIdle) | ((state == StRun) & UPDATE);

  sat_acc #(
    .CW (CW)
  ) u_acc_daq (
    .clk (CLK),
    .rst (RST),
    .clr (acc_clr),
    .inc (mis_daq),
    .sum (sum_daq)
  );

  sat_acc #(
    .CW (CW)
  ) u_acc_trg (
    .clk (CLK),
    .rst (RST),
    .clr (acc_clr),
    .inc (mis_trg),
    .sum (sum_trg)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ADDR <= '0;
    end else if (CLR_ADDR) begin
      ADDR <= '0;
    end else if (INCR) begin
      ADDR <= ADDR + AW'(1);
    end
  end

  // Report registers are loaded on the UPDATE edge so they are visible during the
  // single REPORT cycle. The loaded counts include the UPDATE cycle's own compare.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= StIdle;
      RPT_VLD      <= 1'b0;
      RPT_DAQ_ERRS <= '0;
      RPT_TRG_ERRS <= '0;
      RPT_PASS_CNT <= '0;
      ERR_FLAG     <= 1'b0;
      RPT_OVFL     <= 1'b0;
    end else begin
      // A load below overrides this, so a report coinciding with ACK stays valid.
      if (RPT_ACK) RPT_VLD <= 1'b0;

      unique case (state)
        StIdle: begin
          if (USE_TEST_DATA) begin
            state        <= StRun;
            ERR_FLAG     <= 1'b0;
            RPT_OVFL     <= 1'b0;
            RPT_PASS_CNT <= '0;
          end
        end
        StRun: begin
          if (mis_daq | mis_trg) ERR_FLAG <= 1'b1;
          if (!USE_TEST_DATA) begin
            // Abort: the partial pass is dropped without a report.
            state <= StIdle;
          end else if (UPDATE) begin
            state        <= StReport;
            RPT_DAQ_ERRS <= sum_daq;
            RPT_TRG_ERRS <= sum_trg;
            RPT_PASS_CNT <= RPT_PASS_CNT + CW'(1);
            RPT_VLD      <= 1'b1;
            if (RPT_VLD && !RPT_ACK) RPT_OVFL <= 1'b1;
          end
        end
        StReport: begin
          if (mis_daq | mis_trg) ERR_FLAG <= 1'b1;
          state <= USE_TEST_DATA ? StRun : StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
